// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter with valid/ready intake, per-bit clock divider
// and a sampling strobe for a downstream serial-input shift register.
module serial_word_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    input  logic             msb_first,
    output logic             tx_ready,
    output logic             ser_out,
    output logic             shift_en,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [BW-1:0] BIT_ZERO = BW'(0);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [DW-1:0] DIV_ZERO = DW'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] sreg_r, sreg_s;
    logic [BW-1:0]    bit_cnt_r, bit_cnt_s;
    logic [DW-1:0]    div_cnt_r, div_cnt_s;

    logic tx_ready_r, ser_out_r, shift_en_r, busy_r, done_r;

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] word);
        logic [WIDTH-1:0] res;
        res = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            res[i] = word[WIDTH-1-i];
        end
        return res;
    endfunction

    // Next-state logic: intake in IDLE, divider and bit sequencing in SEND.
    always_comb begin
        state_s   = state_r;
        sreg_s    = sreg_r;
        bit_cnt_s = bit_cnt_r;
        div_cnt_s = div_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (tx_valid) begin
                    sreg_s    = msb_first ? bit_reverse(tx_data) : tx_data;
                    bit_cnt_s = BIT_ZERO;
                    div_cnt_s = DIV_ZERO;
                    state_s   = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (div_cnt_r == DIV_LAST) begin
                    div_cnt_s = DIV_ZERO;
                    if (bit_cnt_r == BIT_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        sreg_s    = {1'b0, sreg_r[WIDTH-1:1]};
                        bit_cnt_s = bit_cnt_r + BIT_ONE;
                    end
                end else begin
                    div_cnt_s = div_cnt_r + DIV_ONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                sreg_s    = {WIDTH{1'b0}};
                bit_cnt_s = BIT_ZERO;
                div_cnt_s = DIV_ZERO;
            end
        endcase
    end

    // State registers and outputs; outputs are precomputed from next state so they
    // come straight from flops yet match the registered-state decode cycle for cycle.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_r    <= ST_IDLE;
            sreg_r     <= {WIDTH{1'b0}};
            bit_cnt_r  <= BIT_ZERO;
            div_cnt_r  <= DIV_ZERO;
            tx_ready_r <= 1'b1;
            ser_out_r  <= 1'b0;
            shift_en_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            sreg_r     <= sreg_s;
            bit_cnt_r  <= bit_cnt_s;
            div_cnt_r  <= div_cnt_s;
            tx_ready_r <= (state_s == ST_IDLE);
            ser_out_r  <= (state_s == ST_SEND) ? sreg_s[0] : 1'b0;
            shift_en_r <= (state_s == ST_SEND) && (div_cnt_s == DIV_LAST);
            busy_r     <= (state_s != ST_IDLE);
            done_r     <= (state_s == ST_DONE);
        end
    end

    assign tx_ready = tx_ready_r;
    assign ser_out  = ser_out_r;
    assign shift_en = shift_en_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: one DIV=1 instance and one DIV=4 instance,
// sharing clock, reset and data inputs, each with its own tx_valid.
module tb_serial_word_tx;

    logic       clk;
    logic       clrn;
    logic [7:0] tx_data;
    logic       msb_first;
    logic       v1, v4;
    logic       r1, s1, e1, b1, d1;
    logic       r4, s4, e4, b4, d4;

    int total = 0;
    int bad   = 0;

    serial_word_tx #(.WIDTH(8), .DIV(1)) dut1 (
        .clk(clk), .clrn(clrn), .tx_data(tx_data), .tx_valid(v1), .msb_first(msb_first),
        .tx_ready(r1), .ser_out(s1), .shift_en(e1), .busy(b1), .done(d1)
    );

    serial_word_tx #(.WIDTH(8), .DIV(4)) dut4 (
        .clk(clk), .clrn(clrn), .tx_data(tx_data), .tx_valid(v4), .msb_first(msb_first),
        .tx_ready(r4), .ser_out(s4), .shift_en(e4), .busy(b4), .done(d4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sampling/driving happens 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready1();
        int n = 0;
        while (!r1 && n < 200) begin
            tick();
            n++;
        end
        if (!r1) check("ready1_timeout", 32'(r1), 32'd1);
    endtask

    // Send one word on the DIV=1 instance; seq[k] is the k-th transmitted bit.
    task automatic send_dut1(input logic [7:0] d, input logic m, input logic [7:0] seq,
                             input string tag);
        wait_ready1();
        tx_data   = d;
        msb_first = m;
        v1        = 1'b1;
        tick();
        v1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_bit%0d", tag, k), 32'(s1), 32'(seq[k]));
            check($sformatf("%s_stb%0d", tag, k), 32'(e1), 32'd1);
            tick();
        end
        check({tag, "_done9"}, 32'(d1), 32'd1);
        check({tag, "_nordy9"}, 32'(r1), 32'd0);
        tick();
        check({tag, "_rdy10"}, 32'(r1), 32'd1);
        check({tag, "_nodone10"}, 32'(d1), 32'd0);
    endtask

    initial begin
        int         strobes;
        int         seen;
        logic [7:0] ref_sr;
        logic [7:0] seq4;

        // Reset held with valid asserted
        clrn      = 1'b0;
        v1        = 1'b1;
        v4        = 1'b1;
        tx_data   = 8'hFF;
        msb_first = 1'b0;
        repeat (3) tick();
        check("rst_ready1", 32'(r1), 32'd1);
        check("rst_ser1",   32'(s1), 32'd0);
        check("rst_stb1",   32'(e1), 32'd0);
        check("rst_busy1",  32'(b1), 32'd0);
        check("rst_done1",  32'(d1), 32'd0);
        check("rst_ready4", 32'(r4), 32'd1);
        check("rst_busy4",  32'(b4), 32'd0);
        v1   = 1'b0;
        v4   = 1'b0;
        clrn = 1'b1;
        tick();
        check("post_rst_busy1",  32'(b1), 32'd0);
        check("post_rst_ready1", 32'(r1), 32'd1);

        // B4 LSB-first: 0,0,1,0,1,1,0,1 ; MSB-first: 1,0,1,1,0,1,0,0
        send_dut1(8'hB4, 1'b0, 8'hB4, "lsb");
        send_dut1(8'hB4, 1'b1, 8'h2D, "msb");

        // DIV=4, word 81 LSB-first: 1,0,0,0,0,0,0,1
        seq4      = 8'h81;
        tx_data   = 8'h81;
        msb_first = 1'b0;
        v4        = 1'b1;
        tick();
        v4      = 1'b0;
        strobes = 0;
        for (int c = 1; c <= 32; c++) begin
            check($sformatf("div4_ser_c%0d", c), 32'(s4), 32'(seq4[(c - 1) / 4]));
            check($sformatf("div4_stb_c%0d", c), 32'(e4), ((c % 4) == 0) ? 32'd1 : 32'd0);
            check($sformatf("div4_nodone_c%0d", c), 32'(d4), 32'd0);
            if (e4) strobes++;
            tick();
        end
        check("div4_done33", 32'(d4), 32'd1);
        check("div4_strobes", 32'(strobes), 32'd8);
        tick();
        check("div4_ready34", 32'(r4), 32'd1);

        // Back-to-back with valid held high; data changes mid-word
        wait_ready1();
        tx_data   = 8'h3C;
        msb_first = 1'b0;
        v1        = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                tx_data   = 8'hFF;
                msb_first = 1'b1;
            end
            check($sformatf("b2b_bit%0d", k), 32'(s1), 32'(k >= 2 && k <= 5));
            check($sformatf("b2b_rdy%0d", k), 32'(r1), 32'd0);
            tick();
        end
        check("b2b_done9",   32'(d1), 32'd1);
        check("b2b_nordy9",  32'(r1), 32'd0);
        tick();
        check("b2b_rdy10",   32'(r1), 32'd1);
        check("b2b_idle10",  32'(b1), 32'd0);
        tick();
        check("b2b_busy11",  32'(b1), 32'd1);
        check("b2b_ser11",   32'(s1), 32'd1);
        check("b2b_stb11",   32'(e1), 32'd1);
        v1 = 1'b0;
        wait_ready1();

        // Mid-word reset after three strobes
        tx_data   = 8'hA5;
        msb_first = 1'b0;
        v1        = 1'b1;
        tick();
        v1      = 1'b0;
        strobes = 0;
        for (int i = 1; i <= 3; i++) begin
            if (e1) strobes++;
            if (i == 3) clrn = 1'b0;
            tick();
        end
        check("mid_strobes", 32'(strobes), 32'd3);
        check("mid_rst_busy", 32'(b1), 32'd0);
        check("mid_rst_stb",  32'(e1), 32'd0);
        check("mid_rst_rdy",  32'(r1), 32'd1);
        clrn = 1'b1;
        seen = 0;
        repeat (12) begin
            if (d1 || e1) seen++;
            tick();
        end
        check("mid_no_done_stb", 32'(seen), 32'd0);

        // Loopback into a right-shift reference register, MSB in on each strobe
        ref_sr    = 8'h00;
        strobes   = 0;
        seen      = 0;
        tx_data   = 8'h5A;
        msb_first = 1'b0;
        v1        = 1'b1;
        tick();
        v1 = 1'b0;
        repeat (12) begin
            if (e1) begin
                ref_sr = {s1, ref_sr[7:1]};
                strobes++;
            end
            if (d1) seen++;
            tick();
        end
        check("loop_word",    32'(ref_sr), 32'h5A);
        check("loop_strobes", 32'(strobes), 32'd8);
        check("loop_done",    32'(seen), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
